// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: bundles the requester-side handshake and the multiplier-side
// operand/result signals of mult_arbiter. The slave modport is the arbiter's
// view; the master modport is the view of whoever drives requests and models
// the multiplier.
interface mult_arbiter_if #(
  parameter int W = 8
);
  // requester side
  logic [1:0]     req;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic [1:0]     gnt;
  logic [2*W-1:0] res;
  logic [1:0]     res_valid;
  logic           err;
  logic           busy;
  // multiplier side
  logic [W-1:0]   m_plicand;
  logic [W-1:0]   m_pliar;
  logic           m_start;
  logic [2*W-1:0] m_product;
  logic           m_done;

  modport slave (
    input  req, a0, b0, a1, b1, m_product, m_done,
    output gnt, res, res_valid, err, busy, m_plicand, m_pliar, m_start
  );

  modport master (
    output req, a0, b0, a1, b1, m_product, m_done,
    input  gnt, res, res_valid, err, busy, m_plicand, m_pliar, m_start
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter/sequencer sharing one sequential WxW
// multiplier between two requesters. One transaction at a time:
// IDLE (arbitrate, latch operands, gnt) -> ISSUE (m_start) -> WAIT (m_done)
// -> RESP (res_valid to owner).
// Optional feature macro: MULT_TIMEOUT_EN -- aborts a WAIT lasting
// TIMEOUT_CYC cycles with res=0 and err pulsed alongside res_valid.
module mult_arbiter #(
  parameter int W           = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]     state_reg;
  logic [1:0]     state_next;
  logic           owner_reg;
  logic           last_reg;
  logic           winner;
  logic [1:0]     gnt_reg;
  logic [1:0]     res_valid_reg;
  logic [2*W-1:0] res_reg;
  logic [W-1:0]   plicand_reg;
  logic [W-1:0]   pliar_reg;
  logic           start_reg;
  logic           busy_reg;
  logic           timeout_hit;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req == 2'b11) begin
      winner = ~last_reg;
    end else begin
      winner = bus.req[1];
    end
  end

  // Transaction sequencing; m_done only matters while in WAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req != 2'b00) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.m_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand latch, result capture and the one-cycle handshake pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      gnt_reg       <= 2'b00;
      res_valid_reg <= 2'b00;
      res_reg       <= '0;
      plicand_reg   <= '0;
      pliar_reg     <= '0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= (state_next != IDLE);
      gnt_reg       <= 2'b00;
      res_valid_reg <= 2'b00;
      start_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req != 2'b00) begin
            owner_reg   <= winner;
            plicand_reg <= winner ? bus.a1 : bus.a0;
            pliar_reg   <= winner ? bus.b1 : bus.b0;
            gnt_reg     <= winner ? 2'b10 : 2'b01;
          end
        end
        ISSUE: begin
          start_reg <= 1'b1;
        end
        WAIT: begin
          if (bus.m_done) begin
            res_reg <= bus.m_product;
          end else if (timeout_hit) begin
            res_reg <= '0;
          end
        end
        RESP: begin
          res_valid_reg <= owner_reg ? 2'b10 : 2'b01;
          last_reg      <= owner_reg;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             abort_reg;
  logic             err_reg;

  // Last permitted WAIT cycle passes without m_done: abort this transaction.
  assign timeout_hit = (state_reg == WAIT) && !bus.m_done &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // Count WAIT cycles from zero on each entry; remember an abort so RESP can flag err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      abort_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ISSUE: wait_cnt_reg <= '0;
        WAIT: begin
          if (timeout_hit) begin
            abort_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          err_reg   <= abort_reg;
          abort_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.gnt       = gnt_reg;
  assign bus.res       = res_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.m_plicand = plicand_reg;
  assign bus.m_pliar   = pliar_reg;
  assign bus.m_start   = start_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed vectors for mult_arbiter. The bench stands in for
// the requesters and for the multiplier (product = latched operands, returned
// after a chosen delay). Expected values are hand-computed constants.
module tb_mult_arbiter;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  mult_arbiter_if #(.W(8)) bus ();

  mult_arbiter #(.W(8), .TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison: count it and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // multiplier stand-in: return product of the latched operands for one cycle
  task automatic pulse_done();
    bus.m_product = bus.m_plicand * bus.m_pliar;
    bus.m_done    = 1'b1;
    tick();
    bus.m_done    = 1'b0;
  endtask

  // one full transaction starting from IDLE with req already driven
  task automatic expect_txn(input string tag, input logic [1:0] exp_gnt,
                            input logic [15:0] exp_res, input int delay,
                            input bit drop_req);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == 2'b00 && n < 10);
    check({tag, "_gnt_latency"}, n, 1);
    check({tag, "_gnt"}, {30'd0, bus.gnt}, {30'd0, exp_gnt});
    check({tag, "_busy"}, {31'd0, bus.busy}, 1);
    if (drop_req) bus.req = 2'b00;
    tick();
    check({tag, "_m_start"}, {31'd0, bus.m_start}, 1);
    check({tag, "_gnt_1cyc"}, {30'd0, bus.gnt}, 0);
    for (int i = 0; i < delay; i++) tick();
    pulse_done();
    check({tag, "_res"}, {16'd0, bus.res}, {16'd0, exp_res});
    check({tag, "_res_valid_early"}, {30'd0, bus.res_valid}, 0);
    tick();
    check({tag, "_res_valid"}, {30'd0, bus.res_valid}, {30'd0, exp_gnt});
    check({tag, "_err"}, {31'd0, bus.err}, 0);
    check({tag, "_busy_after"}, {31'd0, bus.busy}, 0);
  endtask

  // global time bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b0;
    bus.req       = 2'b00;
    bus.a0        = '0;
    bus.b0        = '0;
    bus.a1        = '0;
    bus.b1        = '0;
    bus.m_product = '0;
    bus.m_done    = 1'b0;
    repeat (2) tick();

    // reset values
    check("rst_gnt", {30'd0, bus.gnt}, 0);
    check("rst_res", {16'd0, bus.res}, 0);
    check("rst_res_valid", {30'd0, bus.res_valid}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_m_start", {31'd0, bus.m_start}, 0);
    check("rst_m_plicand", {24'd0, bus.m_plicand}, 0);
    check("rst_err", {31'd0, bus.err}, 0);
    rst = 1'b1;
    tick();

    // single request 12*13, multiplier takes 9 cycles
    bus.req = 2'b01; bus.a0 = 8'd12; bus.b0 = 8'd13;
    expect_txn("single", 2'b01, 16'h009C, 8, 1'b1);

    // both requesting continuously from reset: strict alternation
    rst = 1'b0;
    bus.req = 2'b11;
    bus.a0 = 8'd3; bus.b0 = 8'd5; bus.a1 = 8'd7; bus.b1 = 8'd9;
    tick();
    rst = 1'b1;
    expect_txn("rr0", 2'b01, 16'd15, 2, 1'b0);
    expect_txn("rr1", 2'b10, 16'd63, 3, 1'b0);
    expect_txn("rr2", 2'b01, 16'd15, 1, 1'b0);
    expect_txn("rr3", 2'b10, 16'd63, 4, 1'b0);
    bus.req = 2'b00;
    tick();

    // operands changed after gnt do not affect the transaction
    bus.req = 2'b01; bus.a0 = 8'd12; bus.b0 = 8'd13;
    tick();
    check("opchg_gnt", {30'd0, bus.gnt}, 2'b01);
    bus.req = 2'b00; bus.a0 = 8'd200;
    tick();
    check("opchg_m_plicand", {24'd0, bus.m_plicand}, 12);
    repeat (3) tick();
    pulse_done();
    check("opchg_res", {16'd0, bus.res}, 16'd156);
    tick();
    check("opchg_res_valid", {30'd0, bus.res_valid}, 2'b01);

    // m_done in IDLE is ignored
    bus.m_product = 16'hBEEF; bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    check("done_idle_res", {16'd0, bus.res}, 16'd156);
    check("done_idle_busy", {31'd0, bus.busy}, 0);
    check("done_idle_res_valid", {30'd0, bus.res_valid}, 0);

    // m_done in ISSUE is ignored; transaction completes normally afterwards
    bus.req = 2'b01; bus.a0 = 8'd2; bus.b0 = 8'd3;
    tick();
    check("done_issue_gnt", {30'd0, bus.gnt}, 2'b01);
    bus.req = 2'b00; bus.m_product = 16'h1234; bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    check("done_issue_m_start", {31'd0, bus.m_start}, 1);
    check("done_issue_res", {16'd0, bus.res}, 16'd156);
    repeat (2) tick();
    check("done_issue_still_busy", {31'd0, bus.busy}, 1);
    check("done_issue_no_valid", {30'd0, bus.res_valid}, 0);
    pulse_done();
    check("done_issue_res_final", {16'd0, bus.res}, 16'd6);
    tick();
    check("done_issue_res_valid", {30'd0, bus.res_valid}, 2'b01);

    // reset during WAIT of a requester-1 transaction
    bus.req = 2'b10; bus.a1 = 8'd4; bus.b1 = 8'd5;
    tick();
    check("midrst_gnt", {30'd0, bus.gnt}, 2'b10);
    bus.req = 2'b00;
    repeat (2) tick();
    check("midrst_busy_wait", {31'd0, bus.busy}, 1);
    check("midrst_m_plicand_wait", {24'd0, bus.m_plicand}, 4);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_res", {16'd0, bus.res}, 0);
    check("midrst_m_plicand", {24'd0, bus.m_plicand}, 0);
    check("midrst_res_valid", {30'd0, bus.res_valid}, 0);
    tick();
    bus.a0 = 8'd3; bus.b0 = 8'd5; bus.a1 = 8'd7; bus.b1 = 8'd9;
    bus.req = 2'b11;
    rst = 1'b1;
    expect_txn("midrst_next", 2'b01, 16'd15, 2, 1'b1);

`ifdef MULT_TIMEOUT_EN
    // timeout: m_done never arrives
    begin
      int n;
      bus.req = 2'b01; bus.a0 = 8'd1; bus.b0 = 8'd1;
      tick();
      check("to_gnt", {30'd0, bus.gnt}, 2'b01);
      bus.req = 2'b00;
      tick();
      check("to_m_start", {31'd0, bus.m_start}, 1);
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.res_valid == 2'b00 && n < 200);
      check("to_cycles", n, 65);
      check("to_res", {16'd0, bus.res}, 0);
      check("to_err", {31'd0, bus.err}, 1);
      check("to_res_valid", {30'd0, bus.res_valid}, 2'b01);
      bus.m_product = 16'h5555; bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      tick();
      check("to_late_res", {16'd0, bus.res}, 0);
      check("to_late_busy", {31'd0, bus.busy}, 0);
      check("to_late_valid", {30'd0, bus.res_valid}, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one sequential 8x8 shift-add multiplier between two requesters.
- Requesters are, for example, the switch-operand path and a second operand source.
- Accepts one request at a time, latches its operands, issues a one-cycle start to the multiplier, waits for done, then returns the 16-bit product tagged to the winning requester.
- Sits between the operand sources and the Multiplier instance; its result feeds seg7.

Parameters:
- W, 8: operand width; product is 2*W.
- TIMEOUT_CYC, 64: maximum WAIT cycles before abort (used only with MULT_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- req  in  2  request per requester; held high until matching gnt
- a0  in  W  requester 0 plicand
- b0  in  W  requester 0 pliar
- a1  in  W  requester 1 plicand
- b1  in  W  requester 1 pliar
- gnt  out  2  one-cycle pulse: request accepted, operands latched
- res  out  2*W  last captured product
- res_valid  out  2  one-cycle pulse to the owner when res is updated
- err  out  1  one-cycle pulse with res_valid on timeout abort
- busy  out  1  high in every state except IDLE
- m_plicand  out  W  latched operand a to multiplier
- m_pliar  out  W  latched operand b to multiplier
- m_start  out  1  one-cycle start pulse to multiplier
- m_product  in  2*W  multiplier product
- m_done  in  1  multiplier completion, sampled only in WAIT

Behaviour:
- All outputs registered.
- Reset (rst=0, asynchronous): state=IDLE; gnt, res_valid, err, m_start, busy = 0; res, m_plicand, m_pliar = 0; rr pointer last = 1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the winner.
  - Both requesting: winner = the index != last.
  - One requesting: that one wins.
  - Latch the winner's a/b into m_plicand/m_pliar and store owner id.
  - gnt[owner]=1 for exactly one cycle; go to ISSUE.
  - If req == 0: stay in IDLE.
- ISSUE: m_start=1 for exactly one cycle; go to WAIT. m_done is ignored in this state.
- WAIT:
  - On m_done=1: res <= m_product; go to RESP.
  - m_done asserted in any other state is ignored; no state change, res unchanged.
- RESP: res_valid[owner]=1 for one cycle; last <= owner; go to IDLE.
- Latency: req sampled high in IDLE at edge N gives:
  - gnt at N+1;
  - m_start at N+2;
  - res_valid 2 cycles after the edge that samples m_done.
- A new arbitration occurs no earlier than the cycle after RESP; minimum of 4 cycles per transaction excluding multiplier time.
- req dropped before it is sampled in IDLE: withdrawn, no gnt. req held after gnt: treated as a new request in the next IDLE.
- Continuous requests from both sources strictly alternate 0,1,0,1.
- Operands are sampled only in IDLE; a0/b0/a1/b1 changes after gnt do not affect the transaction.
- res holds its value until the next capture; it is never cleared except by reset or a timeout abort.
- Reset mid-transaction (any state): immediate return to reset values; the in-flight result is discarded with no res_valid.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- With the macro defined:
  - A wait counter (clog2(TIMEOUT_CYC)+1 bits) clears on entry to WAIT.
  - If m_done has not arrived after TIMEOUT_CYC WAIT cycles: res <= 0, go to RESP, err=1 together with res_valid[owner].
  - A late m_done is then ignored.
- Without the macro: WAIT holds indefinitely; err is tied to 0; no counter is synthesized.

Test Plan:
- Reset then req=01, a0=12, b0=13; multiplier done after 9 cycles with product 156 -> gnt=01 one cycle later, m_start pulse, res=0x009C, res_valid=01, busy low after RESP.
- req=11 held continuously from reset, a0=3/b0=5, a1=7/b1=9 -> grants in order 01,10,01,10; results 15,63,15,63 with matching res_valid bits.
- Change a0 from 12 to 200 one cycle after gnt -> result still 156; m_plicand stays 12.
- m_done pulsed in IDLE and in ISSUE -> no state change, res unchanged, no res_valid.
- rst pulsed low during WAIT of a requester-1 transaction -> all outputs return to 0 immediately; the next req=11 grants requester 0 first.
- MULT_TIMEOUT_EN, TIMEOUT_CYC=64, m_done never asserted -> after 64 WAIT cycles res=0, err=1 and res_valid=01 in the same cycle; a late m_done is ignored.
